tone_pwm_gen: RTL

Parametrised successor to the fixed-pitch square-wave sound generator. Plays one note of programmable period for a programmable duration in milliseconds. Volume is set through PWM duty cycle. A start/busy/done handshake lets a sequencer or FSM above it play melodies note by note. Output drives the board audio pin directly.

---
 rtl/tone_pwm_if.sv | 18 +
 rtl/tone_pwm_gen.sv | 69 ++++++
 2 files changed

// File: rtl/tone_pwm_if.sv
// tone_pwm_if: note request/handshake bundle between a sequencer and tone_pwm_gen
interface tone_pwm_if #(
    parameter int CNT_W = 20,
    parameter int VOL_W = 3,
    parameter int DUR_W = 16
);
    logic [CNT_W-1:0] period;
    logic [VOL_W-1:0] vol;
    logic [DUR_W-1:0] duration_ms;
    logic start;
    logic stop;
    logic busy;
    logic done;
    logic sound;

    modport master (output period, vol, duration_ms, start, stop, input busy, done, sound);
    modport slave (input period, vol, duration_ms, start, stop, output busy, done, sound);
endinterface

// File: rtl/tone_pwm_gen.sv
// tone_pwm_gen: plays one PWM-volume square-wave note for a programmable number of ms
module tone_pwm_gen #(
    parameter int CNT_W    = 20,
    parameter int VOL_W    = 3,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    tone_pwm_if.slave  tone
);
    typedef enum logic {IDLE, PLAY} state_t;
    localparam int PRE_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int PRD_W = CNT_W + VOL_W;
    state_t           state;
    logic [CNT_W-1:0] period_l, phase, t_on;
    logic [DUR_W-1:0] dur_l, ms_left;
    logic [PRE_W-1:0] prescaler;
    logic             busy, done, sound;
    logic [PRD_W-1:0] prod;
    logic             ms_tick, timeout;
    // High time is taken from the request inputs so it is ready on the first PLAY edge
    assign prod    = PRD_W'(tone.period >> 1) * (PRD_W'(tone.vol) + PRD_W'(1));
    assign ms_tick = prescaler == PRE_W'(TICK_DIV - 1);
    assign timeout = dur_l != '0 && ms_tick && ms_left == DUR_W'(1);
    assign tone.busy  = busy;
    assign tone.done  = done;
    assign tone.sound = sound;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            period_l  <= '0;
            phase     <= '0;
            t_on      <= '0;
            dur_l     <= '0;
            ms_left   <= '0;
            prescaler <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sound     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (tone.start && !tone.stop) begin
                    period_l  <= tone.period;
                    t_on      <= CNT_W'(prod >> VOL_W);
                    dur_l     <= tone.duration_ms;
                    ms_left   <= tone.duration_ms;
                    phase     <= '0;
                    prescaler <= '0;
                    state     <= PLAY;
                    busy      <= 1'b1;
                end
                sound <= 1'b0;
            end else if (tone.stop || timeout) begin
                state <= IDLE;
                busy  <= 1'b0;
                sound <= 1'b0;
                done  <= 1'b1;
            end else begin
                // Periods below 2 encode a silent rest
                sound     <= period_l >= CNT_W'(2) && phase < t_on;
                phase     <= phase == period_l - CNT_W'(1) ? '0 : phase + CNT_W'(1);
                prescaler <= ms_tick ? '0 : prescaler + PRE_W'(1);
                if (ms_tick && dur_l != '0) ms_left <= ms_left - DUR_W'(1);
            end
        end
    end
endmodule
